// File: rtl/pc_unit.sv
// Program-counter stage: holds the PC, evaluates Bcond/Jcond conditions
// against the ALU flags, and supplies the JAL link value (PC+1).
module pc_unit #(
  parameter int ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pc_en,
  input  logic                  branch,
  input  logic                  jump,
  input  logic [15:0]           instruction,
  input  logic [4:0]            flags,
  input  logic [ADDR_WIDTH-1:0] rtarget,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] link_data,
  output logic                  link_wr,
  output logic                  taken,
  output logic                  illegal
);

  logic                  flag_c, flag_l, flag_f, flag_z, flag_n;
  logic [3:0]            cond;
  logic                  cond_true;
  logic                  is_jal;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [ADDR_WIDTH-1:0] pc_disp;
  logic [ADDR_WIDTH-1:0] next_pc;
  logic                  next_taken;
  logic                  unused_bits;

  assign {flag_c, flag_l, flag_f, flag_z, flag_n} = flags;
  assign cond   = instruction[11:8];
  assign is_jal = (instruction[7:4] == 4'b1000);

  // Opcode and register-select bits are decoded elsewhere.
  assign unused_bits = ^{instruction[15:12], instruction[3:0]};

  always_comb begin
    cond_true = 1'b0;
    case (cond)
      4'h0: cond_true = flag_z;
      4'h1: cond_true = !flag_z;
      4'h2: cond_true = flag_c;
      4'h3: cond_true = !flag_c;
      4'h4: cond_true = flag_l;
      4'h5: cond_true = !flag_l;
      4'h6: cond_true = flag_n;
      4'h7: cond_true = !flag_n;
      4'h8: cond_true = flag_f;
      4'h9: cond_true = !flag_f;
      4'hA: cond_true = !flag_l && !flag_z;
      4'hB: cond_true = flag_l || flag_z;
      4'hC: cond_true = !flag_n && !flag_z;
      4'hD: cond_true = flag_n || flag_z;
      4'hE: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  assign pc_inc    = pc + ADDR_WIDTH'(1);
  assign pc_disp   = pc + {{(ADDR_WIDTH-8){instruction[7]}}, instruction[7:0]};
  assign link_data = pc_inc;
  assign link_wr   = pc_en && jump && is_jal;

  // Jump takes priority over branch, which also covers the illegal both-set case.
  always_comb begin
    next_pc    = pc_inc;
    next_taken = 1'b0;
    if (jump) begin
      if (is_jal || cond_true) begin
        next_pc    = rtarget;
        next_taken = 1'b1;
      end
    end else if (branch) begin
      if (cond_true) begin
        next_pc    = pc_disp;
        next_taken = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= RESET_VECTOR;
      taken   <= 1'b0;
      illegal <= 1'b0;
    end else if (pc_en) begin
      pc    <= next_pc;
      taken <= next_taken;
      if (branch && jump) illegal <= 1'b1;
    end
  end

endmodule
